iomem_gpio: RTL and testbench
=============================

IOMEM_GPIO -- requirements
Module: iomem_gpio

Interface
REQ-001 SHALL have parameter NUM_GPIO, default 8, number of GPIO channels, legal 1..32.
REQ-002 SHALL have parameter BASE_ADDR, default 8'h03, iomem_addr[31:24] decode value.
REQ-003 SHALL have parameter RST_OUT, default 0, reset value of OUT register (NUM_GPIO bits).
REQ-004 SHALL have port sys_clk  in  1  sole clock; all logic rising-edge.
REQ-005 SHALL have port resetn  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port iomem_valid  in  1  bus request.
REQ-007 SHALL have port iomem_wstrb  in  4  byte write strobes; 0 = read.
REQ-008 SHALL have port iomem_addr  in  32  byte address.
REQ-009 SHALL have port iomem_wdata  in  32  write data.
REQ-010 SHALL have port iomem_ready  out  1  one-cycle completion pulse, registered.
REQ-011 SHALL have port iomem_rdata  out  32  read data, valid while iomem_ready=1, else 0.
REQ-012 SHALL have port gpio_in  in  NUM_GPIO  asynchronous pin inputs.
REQ-013 SHALL have port gpio_out  out  NUM_GPIO  pin output values.
REQ-014 SHALL have port gpio_oe  out  NUM_GPIO  output enables, 1 = drive.
REQ-015 SHALL have port irq  out  1  level interrupt, registered.

Function
REQ-016 SHALL select when iomem_valid=1 and iomem_addr[31:24]=BASE_ADDR; register offset = iomem_addr[4:2].
REQ-017 SHALL map offsets: 0 OUT rw; 1 DIR rw; 2 IN ro; 3 IRQ_EN rw; 4 IRQ_STAT rw1c; 5 BLINK_MASK rw; 6 BLINK_DIV rw (32-bit); 7 unmapped.
REQ-018 SHALL, for a selected request with iomem_ready=0, assert iomem_ready exactly one cycle later for one cycle; no back-to-back ready; next access accepted the cycle after ready drops.
REQ-019 SHALL apply writes per byte lane per iomem_wstrb in the cycle ready is registered; rdata returns pre-write value.
REQ-020 SHALL read bits at and above NUM_GPIO as 0 and ignore writes to them for OUT, DIR, IN, IRQ_EN, IRQ_STAT, BLINK_MASK.
REQ-021 SHALL complete unmapped offset 7 normally: rdata 0, writes ignored.
REQ-022 SHALL never assert iomem_ready for unselected addresses; rdata stays 0.
REQ-023 SHALL synchronise gpio_in through two flops; IN reads the second stage (2-cycle latency).
REQ-024 SHALL set IRQ_STAT[i] on a rising edge of synchronised gpio_in[i] (second stage 1, third stage 0), independent of IRQ_EN.
REQ-025 SHALL clear IRQ_STAT[i] on a write of 1 to that bit; a set event in the same cycle wins.
REQ-026 SHALL drive irq = |(IRQ_STAT & IRQ_EN), registered, one cycle after the state change.
REQ-027 SHALL run a 32-bit blink counter: BLINK_DIV=0 -> counter and phase held 0; else counter increments each cycle, on reaching BLINK_DIV-1 wraps to 0 and toggles phase.
REQ-028 SHALL clear the counter and phase on any write to BLINK_DIV.
REQ-029 SHALL drive gpio_out = OUT ^ (BLINK_MASK & {NUM_GPIO{phase}}), registered; gpio_oe = DIR.

Reset
REQ-030 SHALL on resetn=0 set OUT=RST_OUT, DIR, IRQ_EN, IRQ_STAT, BLINK_MASK, BLINK_DIV, counter, phase, sync flops, iomem_ready, irq all 0; gpio_out=RST_OUT next cycle.
REQ-031 SHALL abandon an in-flight access on reset: no ready pulse after reset release; the master must reissue.

Verification
REQ-032 SHALL verify: write DIR=0xFF wstrb=0001 at 0x03000004, then read -> ready one cycle after valid, rdata=0x000000FF, gpio_oe=0xFF.
REQ-033 SHALL verify: write OUT=0xFFFFFFFF, NUM_GPIO=8 -> readback 0x000000FF; read 0x0300001C -> ready, rdata 0; read 0x04000000 -> no ready for 20 cycles.
REQ-034 SHALL verify: IRQ_EN=0x01, gpio_in[0] 0->1 -> IN[0]=1 after 2 cycles, IRQ_STAT=0x01, irq=1 one cycle later; W1C 0x01 -> irq=0.
REQ-035 SHALL verify: BLINK_MASK=0x02, BLINK_DIV=4, OUT=0 -> gpio_out[1] toggles every 4 cycles; BLINK_DIV=0 -> gpio_out[1]=0 steady.
REQ-036 SHALL verify: W1C of IRQ_STAT[0] coincident with new rising edge on gpio_in[0] -> IRQ_STAT[0] stays 1.
REQ-037 SHALL verify: resetn=0 mid-access with RST_OUT=0xA5 -> no ready, all registers 0, gpio_out=0xA5.

Source files
------------

// File: rtl/iomem_gpio_if.sv
// iomem_gpio_if: iomem request/response bundle between a CPU-side master and a peripheral.
// Latency: none in the bundle itself; the slave answers a request with a one-cycle ready pulse.
// Backpressure: master holds valid/addr/wstrb/wdata stable until it sees ready, then drops or reissues.
// Ports: iomem_valid, iomem_wstrb (0 = read), iomem_addr, iomem_wdata from master;
//        iomem_ready, iomem_rdata from slave.
interface iomem_gpio_if;
  logic        iomem_valid;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic        iomem_ready;
  logic [31:0] iomem_rdata;

  modport master (
    output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    input  iomem_ready, iomem_rdata
  );

  modport slave (
    input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    output iomem_ready, iomem_rdata
  );
endinterface

// File: rtl/iomem_gpio.sv
// iomem_gpio: memory-mapped GPIO block with pin-edge interrupts and a blink generator.
// Latency: bus access completes with a registered ready one cycle after a selected request.
// Backpressure: at most one access every other cycle; a request seen while ready is high waits.
//
// Ports:
//   sys_clk, resetn        - clock, synchronous active-low reset
//   bus (slave modport)    - iomem valid/wstrb/addr/wdata in, ready/rdata out
//   gpio_in                - asynchronous pin inputs (double-flopped internally)
//   gpio_out, gpio_oe      - registered pin values and output enables (1 = drive)
//   irq                    - registered level interrupt, |(IRQ_STAT & IRQ_EN)
//
// Register map (iomem_addr[4:2]):
//   0 OUT  rw | 1 DIR rw | 2 IN ro | 3 IRQ_EN rw | 4 IRQ_STAT rw1c
//   5 BLINK_MASK rw | 6 BLINK_DIV rw (32 bit) | 7 unmapped (reads 0)
module iomem_gpio #(
  parameter int          NUM_GPIO  = 8,
  parameter logic [7:0]  BASE_ADDR = 8'h03,
  parameter logic [31:0] RST_OUT   = 32'h0
) (
  input  logic                sys_clk,
  input  logic                resetn,
  iomem_gpio_if.slave         bus,
  input  logic [NUM_GPIO-1:0] gpio_in,
  output logic [NUM_GPIO-1:0] gpio_out,
  output logic [NUM_GPIO-1:0] gpio_oe,
  output logic                irq
);

  localparam logic [NUM_GPIO-1:0] RST_OUT_G = RST_OUT[NUM_GPIO-1:0];

  localparam logic [2:0] OFF_OUT        = 3'd0;
  localparam logic [2:0] OFF_DIR        = 3'd1;
  localparam logic [2:0] OFF_IN         = 3'd2;
  localparam logic [2:0] OFF_IRQ_EN     = 3'd3;
  localparam logic [2:0] OFF_IRQ_STAT   = 3'd4;
  localparam logic [2:0] OFF_BLINK_MASK = 3'd5;
  localparam logic [2:0] OFF_BLINK_DIV  = 3'd6;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [NUM_GPIO-1:0] out_q;
  logic [NUM_GPIO-1:0] dir_q;
  logic [NUM_GPIO-1:0] irq_en_q;
  logic [NUM_GPIO-1:0] irq_stat_q;
  logic [NUM_GPIO-1:0] blink_mask_q;
  logic [31:0]         blink_div_q;
  logic [31:0]         blink_cnt_q;
  logic                phase_q;

  // sync1/sync2 form the metastability synchroniser; sync3 is the previous
  // value of sync2 and exists only for rising-edge detection.
  logic [NUM_GPIO-1:0] sync1_q;
  logic [NUM_GPIO-1:0] sync2_q;
  logic [NUM_GPIO-1:0] sync3_q;

  logic                ready_q;
  logic [31:0]         rdata_q;
  logic [NUM_GPIO-1:0] gpio_out_q;
  logic                irq_q;

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic [2:0]  offset;
  logic        sel;
  logic        accept;
  logic        wr_en;
  logic [31:0] rd_val;
  logic [31:0] lane_mask;
  logic [31:0] wr_val;

  // Address bits outside the decode and offset fields are don't-care.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.iomem_addr[23:5], bus.iomem_addr[1:0]};

  assign offset = bus.iomem_addr[4:2];
  assign sel    = bus.iomem_valid && (bus.iomem_addr[31:24] == BASE_ADDR);
  // Gating on ready_q stops a still-asserted request from being taken twice
  // while the master is seeing its completion pulse.
  assign accept = sel && !ready_q;
  assign wr_en  = accept && (bus.iomem_wstrb != 4'b0000);

  function automatic logic [31:0] zext(input logic [NUM_GPIO-1:0] v);
    logic [31:0] r;
    r = '0;
    r[NUM_GPIO-1:0] = v;
    return r;
  endfunction

  // Current (pre-write) value of the addressed register, zero-extended.
  always_comb begin
    rd_val = '0;
    case (offset)
      OFF_OUT:        rd_val = zext(out_q);
      OFF_DIR:        rd_val = zext(dir_q);
      OFF_IN:         rd_val = zext(sync2_q);
      OFF_IRQ_EN:     rd_val = zext(irq_en_q);
      OFF_IRQ_STAT:   rd_val = zext(irq_stat_q);
      OFF_BLINK_MASK: rd_val = zext(blink_mask_q);
      OFF_BLINK_DIV:  rd_val = blink_div_q;
      default:        rd_val = '0;
    endcase
  end

  always_comb begin
    lane_mask = '0;
    for (int b = 0; b < 4; b++) begin
      lane_mask[8*b +: 8] = {8{bus.iomem_wstrb[b]}};
    end
  end

  // Byte-lane merge of write data over the register's current value; the
  // per-register truncation to NUM_GPIO bits drops anything above the pins.
  assign wr_val = (rd_val & ~lane_mask) | (bus.iomem_wdata & lane_mask);

  // ---------------------------------------------------------------------------
  // Interrupt status
  // ---------------------------------------------------------------------------
  logic [NUM_GPIO-1:0] rise;
  logic [NUM_GPIO-1:0] stat_clr;
  logic [NUM_GPIO-1:0] stat_nxt;

  assign rise     = sync2_q & ~sync3_q;
  assign stat_clr = (wr_en && offset == OFF_IRQ_STAT)
                    ? (bus.iomem_wdata[NUM_GPIO-1:0] & lane_mask[NUM_GPIO-1:0])
                    : '0;
  // OR-ing the edge in after the clear lets a same-cycle event survive a W1C.
  assign stat_nxt = (irq_stat_q & ~stat_clr) | rise;

  // ---------------------------------------------------------------------------
  // Blink generator
  // ---------------------------------------------------------------------------
  logic blink_wr;
  assign blink_wr = wr_en && (offset == OFF_BLINK_DIV);

  // ---------------------------------------------------------------------------
  // Sequential logic
  // ---------------------------------------------------------------------------
  always_ff @(posedge sys_clk) begin
    if (!resetn) begin
      out_q        <= RST_OUT_G;
      dir_q        <= '0;
      irq_en_q     <= '0;
      irq_stat_q   <= '0;
      blink_mask_q <= '0;
      blink_div_q  <= '0;
      blink_cnt_q  <= '0;
      phase_q      <= 1'b0;
      sync1_q      <= '0;
      sync2_q      <= '0;
      sync3_q      <= '0;
      ready_q      <= 1'b0;
      rdata_q      <= '0;
      gpio_out_q   <= RST_OUT_G;
      irq_q        <= 1'b0;
    end else begin
      sync1_q <= gpio_in;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;

      ready_q <= accept;
      rdata_q <= accept ? rd_val : 32'h0;

      if (wr_en) begin
        case (offset)
          OFF_OUT:        out_q        <= wr_val[NUM_GPIO-1:0];
          OFF_DIR:        dir_q        <= wr_val[NUM_GPIO-1:0];
          OFF_IRQ_EN:     irq_en_q     <= wr_val[NUM_GPIO-1:0];
          OFF_BLINK_MASK: blink_mask_q <= wr_val[NUM_GPIO-1:0];
          OFF_BLINK_DIV:  blink_div_q  <= wr_val;
          default: ;
        endcase
      end

      irq_stat_q <= stat_nxt;

      // Phase toggles each time the counter completes BLINK_DIV cycles; a
      // divider write restarts the pattern from a known phase.
      if (blink_wr || blink_div_q == 32'h0) begin
        blink_cnt_q <= '0;
        phase_q     <= 1'b0;
      end else if (blink_cnt_q == blink_div_q - 32'h1) begin
        blink_cnt_q <= '0;
        phase_q     <= ~phase_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + 32'h1;
      end

      gpio_out_q <= out_q ^ (blink_mask_q & {NUM_GPIO{phase_q}});
      irq_q      <= |(irq_stat_q & irq_en_q);
    end
  end

  assign bus.iomem_ready = ready_q;
  assign bus.iomem_rdata = rdata_q;
  assign gpio_out        = gpio_out_q;
  assign gpio_oe         = dir_q;
  assign irq             = irq_q;

endmodule

// File: tb/tb_iomem_gpio.sv
// tb_iomem_gpio: scenario tasks plus a randomized register-map run against a
// per-offset model of the programmer-visible registers.
module tb_iomem_gpio;
  localparam int NG = 8;
  localparam logic [31:0] GMASK = 32'h0000_00FF;

  logic          sys_clk = 1'b0;
  logic          resetn;
  logic [NG-1:0] gpio_in;
  logic [NG-1:0] gpio_out;
  logic [NG-1:0] gpio_oe;
  logic          irq;

  int tests_run    = 0;
  int tests_failed = 0;

  iomem_gpio_if bus();

  iomem_gpio #(
    .NUM_GPIO (NG),
    .BASE_ADDR(8'h03),
    .RST_OUT  (32'hA5)
  ) dut (
    .sys_clk (sys_clk),
    .resetn  (resetn),
    .bus     (bus),
    .gpio_in (gpio_in),
    .gpio_out(gpio_out),
    .gpio_oe (gpio_oe),
    .irq     (irq)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called #1 after a clock edge with ready low. Returns #1 after the edge
  // following the completion (or timeout), so ready is low again on return.
  task automatic access(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] wd,
                        input int max_cyc, output logic got, output logic [31:0] rd,
                        output int lat, output logic leak);
    bus.iomem_valid = 1'b1;
    bus.iomem_addr  = addr;
    bus.iomem_wstrb = strb;
    bus.iomem_wdata = wd;
    got = 1'b0; rd = '0; lat = 0; leak = 1'b0;
    while (!got && lat < max_cyc) begin
      @(posedge sys_clk); #1;
      lat++;
      if (bus.iomem_ready) begin
        got = 1'b1;
        rd  = bus.iomem_rdata;
      end else if (bus.iomem_rdata !== 32'h0) begin
        leak = 1'b1;
      end
    end
    bus.iomem_valid = 1'b0;
    bus.iomem_wstrb = 4'h0;
    @(posedge sys_clk); #1;
  endtask

  task automatic reg_acc(input logic [2:0] off, input logic [3:0] strb, input logic [31:0] wd,
                         output logic got, output logic [31:0] rd);
    int   lat;
    logic leak;
    access({8'h03, 19'h0, off, 2'b00}, strb, wd, 4, got, rd, lat, leak);
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge sys_clk); #1; end
  endtask

  task automatic test_reset;
    logic got; logic [31:0] rd, exp;
    if (bus.iomem_ready !== 1'b0 || bus.iomem_rdata !== 32'h0) begin
      tests_failed++; $display("FAIL reset_bus ready=%b rdata=%h want 0/0", bus.iomem_ready, bus.iomem_rdata);
    end
    tests_run++;
    if (gpio_out !== 8'hA5 || gpio_oe !== 8'h00 || irq !== 1'b0) begin
      tests_failed++; $display("FAIL reset_pins out=%h oe=%h irq=%b want a5/00/0", gpio_out, gpio_oe, irq);
    end
    tests_run++;
    for (int o = 0; o < 8; o++) begin
      exp = (o == 0) ? 32'hA5 : 32'h0;
      reg_acc(3'(o), 4'h0, 32'h0, got, rd);
      if (got !== 1'b1 || rd !== exp) begin
        tests_failed++; $display("FAIL reset_reg%0d got=%b rdata=%h want %h", o, got, rd, exp);
      end
      tests_run++;
    end
  endtask

  task automatic test_dir_rw;
    logic got, leak; logic [31:0] rd; int lat;
    access(32'h0300_0004, 4'b0001, 32'h0000_00FF, 4, got, rd, lat, leak);
    if (got !== 1'b1 || lat != 1) begin
      tests_failed++; $display("FAIL dir_write_latency got=%b lat=%0d want 1/1", got, lat);
    end
    tests_run++;
    access(32'h0300_0004, 4'b0000, 32'h0, 4, got, rd, lat, leak);
    if (got !== 1'b1 || lat != 1 || rd !== 32'h0000_00FF) begin
      tests_failed++; $display("FAIL dir_read got=%b lat=%0d rdata=%h want 1/1/000000ff", got, lat, rd);
    end
    tests_run++;
    if (gpio_oe !== 8'hFF) begin
      tests_failed++; $display("FAIL dir_oe oe=%h want ff", gpio_oe);
    end
    tests_run++;
  endtask

  task automatic test_width_unmapped;
    logic got, leak; logic [31:0] rd; int lat;
    reg_acc(3'd0, 4'hF, 32'hFFFF_FFFF, got, rd);
    reg_acc(3'd0, 4'h0, 32'h0, got, rd);
    if (got !== 1'b1 || rd !== 32'h0000_00FF) begin
      tests_failed++; $display("FAIL out_width got=%b rdata=%h want 000000ff", got, rd);
    end
    tests_run++;
    reg_acc(3'd0, 4'b0001, 32'hFFFF_FF12, got, rd);
    reg_acc(3'd0, 4'b0010, 32'h0000_5500, got, rd);
    reg_acc(3'd0, 4'h0, 32'h0, got, rd);
    if (rd !== 32'h0000_0012) begin
      tests_failed++; $display("FAIL out_lanes rdata=%h want 00000012", rd);
    end
    tests_run++;
    reg_acc(3'd2, 4'hF, 32'hFFFF_FFFF, got, rd);
    reg_acc(3'd2, 4'h0, 32'h0, got, rd);
    if (got !== 1'b1 || rd !== 32'h0) begin
      tests_failed++; $display("FAIL in_readonly got=%b rdata=%h want 0", got, rd);
    end
    tests_run++;
    access(32'h0300_001C, 4'hF, 32'hFFFF_FFFF, 4, got, rd, lat, leak);
    access(32'h0300_001C, 4'h0, 32'h0, 4, got, rd, lat, leak);
    if (got !== 1'b1 || lat != 1 || rd !== 32'h0) begin
      tests_failed++; $display("FAIL unmapped got=%b lat=%0d rdata=%h want 1/1/0", got, lat, rd);
    end
    tests_run++;
    access(32'h0400_0000, 4'h0, 32'h0, 20, got, rd, lat, leak);
    if (got !== 1'b0 || leak !== 1'b0) begin
      tests_failed++; $display("FAIL unselected ready=%b rdata_nonzero=%b want 0/0", got, leak);
    end
    tests_run++;
  endtask

  task automatic test_back_to_back;
    logic exp;
    bus.iomem_addr  = 32'h0300_0000;
    bus.iomem_wstrb = 4'h0;
    bus.iomem_valid = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge sys_clk); #1;
      exp = (k % 2) == 1;
      if (bus.iomem_ready !== exp || (exp && bus.iomem_rdata !== 32'h12)) begin
        tests_failed++; $display("FAIL b2b_cycle%0d ready=%b rdata=%h want %b/12", k, bus.iomem_ready, bus.iomem_rdata, exp);
      end
      tests_run++;
    end
    bus.iomem_valid = 1'b0;
    cycles(1);
  endtask

  task automatic test_irq;
    logic got; logic [31:0] rd;
    reg_acc(3'd3, 4'h1, 32'h01, got, rd);
    reg_acc(3'd4, 4'h1, 32'hFF, got, rd);
    gpio_in[0] = 1'b1;
    reg_acc(3'd2, 4'h0, 32'h0, got, rd);
    if (rd !== 32'h0) begin
      tests_failed++; $display("FAIL in_too_early rdata=%h want 0", rd);
    end
    tests_run++;
    if (irq !== 1'b0) begin
      tests_failed++; $display("FAIL irq_early_a irq=%b want 0", irq);
    end
    tests_run++;
    cycles(1);
    if (irq !== 1'b0) begin
      tests_failed++; $display("FAIL irq_early_b irq=%b want 0", irq);
    end
    tests_run++;
    cycles(1);
    if (irq !== 1'b1) begin
      tests_failed++; $display("FAIL irq_assert irq=%b want 1", irq);
    end
    tests_run++;
    reg_acc(3'd2, 4'h0, 32'h0, got, rd);
    if (rd !== 32'h01) begin
      tests_failed++; $display("FAIL in_bit0 rdata=%h want 00000001", rd);
    end
    tests_run++;
    reg_acc(3'd4, 4'h0, 32'h0, got, rd);
    if (rd !== 32'h01) begin
      tests_failed++; $display("FAIL stat_set rdata=%h want 00000001", rd);
    end
    tests_run++;
    reg_acc(3'd4, 4'h1, 32'h01, got, rd);
    if (irq !== 1'b0) begin
      tests_failed++; $display("FAIL irq_w1c irq=%b want 0", irq);
    end
    tests_run++;
    gpio_in[3] = 1'b1;
    cycles(5);
    reg_acc(3'd4, 4'h0, 32'h0, got, rd);
    if (rd !== 32'h08 || irq !== 1'b0) begin
      tests_failed++; $display("FAIL stat_unenabled rdata=%h irq=%b want 00000008/0", rd, irq);
    end
    tests_run++;
    reg_acc(3'd4, 4'h1, 32'h08, got, rd);
    reg_acc(3'd4, 4'h0, 32'h0, got, rd);
    if (rd !== 32'h0) begin
      tests_failed++; $display("FAIL stat_cleared rdata=%h want 0", rd);
    end
    tests_run++;
  endtask

  task automatic test_w1c_race;
    logic got; logic [31:0] rd;
    gpio_in = '0;
    cycles(5);
    gpio_in[0] = 1'b1;
    cycles(2);
    // The W1C below is accepted on the same edge the synchronised rise lands.
    reg_acc(3'd4, 4'h1, 32'h01, got, rd);
    reg_acc(3'd4, 4'h0, 32'h0, got, rd);
    if (rd !== 32'h01 || irq !== 1'b1) begin
      tests_failed++; $display("FAIL w1c_race stat=%h irq=%b want 00000001/1", rd, irq);
    end
    tests_run++;
    reg_acc(3'd4, 4'h1, 32'h01, got, rd);
    gpio_in = '0;
    cycles(4);
  endtask

  task automatic test_blink;
    logic got; logic [31:0] rd; logic [NG-1:0] exp;
    reg_acc(3'd0, 4'hF, 32'h0, got, rd);
    reg_acc(3'd6, 4'hF, 32'h0, got, rd);
    reg_acc(3'd5, 4'hF, 32'h02, got, rd);
    reg_acc(3'd6, 4'hF, 32'd4, got, rd);
    // j counts edges since the divider write; the pin shows the phase of the
    // previous edge, and the phase flips once per 4 elapsed cycles.
    for (int j = 1; j <= 24; j++) begin
      exp = (((j - 1) / 4) % 2 == 1) ? 8'h02 : 8'h00;
      if (gpio_out !== exp) begin
        tests_failed++; $display("FAIL blink_j%0d gpio_out=%h want %h", j, gpio_out, exp);
      end
      tests_run++;
      cycles(1);
    end
    reg_acc(3'd6, 4'hF, 32'h0, got, rd);
    for (int j = 0; j < 20; j++) begin
      if (gpio_out !== 8'h00) begin
        tests_failed++; $display("FAIL blink_off_j%0d gpio_out=%h want 00", j, gpio_out);
      end
      tests_run++;
      cycles(1);
    end
  endtask

  task automatic test_reset_mid;
    logic got; logic [31:0] rd, exp;
    reg_acc(3'd0, 4'hF, 32'h3C, got, rd);
    reg_acc(3'd1, 4'hF, 32'hFF, got, rd);
    reg_acc(3'd3, 4'hF, 32'hFF, got, rd);
    reg_acc(3'd5, 4'hF, 32'hFF, got, rd);
    reg_acc(3'd6, 4'hF, 32'd3, got, rd);
    gpio_in = 8'h10;
    cycles(5);
    gpio_in = '0;
    cycles(4);
    bus.iomem_addr  = 32'h0300_0000;
    bus.iomem_wstrb = 4'h0;
    bus.iomem_valid = 1'b1;
    resetn = 1'b0;
    for (int k = 0; k < 7; k++) begin
      @(posedge sys_clk); #1;
      if (k == 0) bus.iomem_valid = 1'b0;
      if (k == 1) resetn = 1'b1;
      if (bus.iomem_ready !== 1'b0) begin
        tests_failed++; $display("FAIL rst_mid_ready_k%0d ready=%b want 0", k, bus.iomem_ready);
      end
      tests_run++;
    end
    if (gpio_out !== 8'hA5 || gpio_oe !== 8'h00 || irq !== 1'b0) begin
      tests_failed++; $display("FAIL rst_mid_pins out=%h oe=%h irq=%b want a5/00/0", gpio_out, gpio_oe, irq);
    end
    tests_run++;
    for (int o = 0; o < 8; o++) begin
      exp = (o == 0) ? 32'hA5 : 32'h0;
      reg_acc(3'(o), 4'h0, 32'h0, got, rd);
      if (got !== 1'b1 || rd !== exp) begin
        tests_failed++; $display("FAIL rst_mid_reg%0d got=%b rdata=%h want %h", o, got, rd, exp);
      end
      tests_run++;
    end
  endtask

  // Model: one 32-bit value per offset holding what software should read back.
  task automatic test_random_regs;
    logic [31:0]   m [8];
    logic [31:0]   addr, wd, rd, exp_rd, lanes;
    logic [3:0]    strb;
    logic [2:0]    off;
    logic          sel, got, leak;
    logic [NG-1:0] pins;
    int            lat;
    for (int i = 0; i < 8; i++) m[i] = 32'h0;
    m[0] = 32'hA5;
    pins = NG'($urandom);
    gpio_in = pins;
    cycles(5);
    m[2] = {24'h0, pins};
    m[4] = {24'h0, pins};   // every pin that went 0->1 latched a status bit
    for (int n = 0; n < 80; n++) begin
      sel  = ($urandom_range(0, 7) != 0);
      off  = 3'($urandom_range(0, 7));
      strb = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      wd   = $urandom;
      addr = $urandom;
      addr[31:24] = sel ? 8'h03 : 8'($urandom_range(4, 255));
      addr[4:2]   = off;
      exp_rd = m[off];
      access(addr, strb, wd, 4, got, rd, lat, leak);
      if (sel && strb != 4'h0) begin
        lanes = 32'h0;
        for (int b = 0; b < 4; b++) if (strb[b]) lanes[8*b +: 8] = 8'hFF;
        case (off)
          3'd0, 3'd1, 3'd3, 3'd5: m[off] = ((m[off] & ~lanes) | (wd & lanes)) & GMASK;
          3'd4:                   m[4]   = m[4] & ~(wd & lanes);
          3'd6:                   m[6]   = (m[6] & ~lanes) | (wd & lanes);
          default: ;
        endcase
      end
      if (got !== sel || (sel && rd !== exp_rd) || (!sel && leak)) begin
        tests_failed++;
        $display("FAIL rand%0d addr=%h strb=%h ready=%b rdata=%h want ready=%b rdata=%h", n, addr, strb, got, rd, sel, exp_rd);
      end
      tests_run++;
      if (gpio_oe !== m[1][NG-1:0] || irq !== |(m[3] & m[4])) begin
        tests_failed++;
        $display("FAIL rand%0d_pins oe=%h irq=%b want %h/%b", n, gpio_oe, irq, m[1][NG-1:0], |(m[3] & m[4]));
      end
      tests_run++;
    end
  endtask

  initial begin
    resetn          = 1'b0;
    gpio_in         = '0;
    bus.iomem_valid = 1'b0;
    bus.iomem_wstrb = 4'h0;
    bus.iomem_addr  = 32'h0;
    bus.iomem_wdata = 32'h0;
    repeat (3) @(posedge sys_clk);
    #1;
    resetn = 1'b1;

    test_reset();
    test_dir_rw();
    test_width_unmapped();
    test_back_to_back();
    test_irq();
    test_w1c_race();
    test_blink();
    test_reset_mid();
    test_random_regs();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
